adder_pipe_sched: RTL and testbench
===================================

# adder_pipe_sched

Scheduler that shares one `adder_pipe` instance (sum of ADD_NUM operands, fixed latency PIPE_LAT) between REQ_NUM PE-row requesters in the CNN datapath. It arbitrates round-robin and locks the grant for a whole accumulation window, which is a run of VALID beats closed by CNN_FIN or COMPL. It drives the adder's `status_in`/`data_in`, tags every beat with its requester id, and routes `status_out`/`data_out` back to the owner. When every requester has sent COMPL and the pipe has drained, it pulses `all_done`.

## Interface
- DATA_WID, 8, operand/result width (signed)
- ADD_NUM, 4, operands per beat; matches the adder_pipe ADD_NUM
- REQ_NUM, 2, requesters (≥2); ID_WID = $clog2(REQ_NUM)
- PIPE_LAT, 2, adder_pipe latency in cycles, status_in to status_out
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- req_valid  in  [REQ_NUM]  requester i presents a beat
- req_status  in  PE_STATE [REQ_NUM]  beat status (VALID / CNN_FIN / COMPL)
- req_data  in  signed [DATA_WID] [REQ_NUM][ADD_NUM]  operands
- req_ready  out  [REQ_NUM]  one-hot grant; a beat is accepted when req_valid[i] & req_ready[i]
- add_status  out  PE_STATE  to adder_pipe status_in
- add_data  out  signed [DATA_WID] [ADD_NUM]  to adder_pipe data_in
- add_status_ret  in  PE_STATE  from adder_pipe status_out
- add_data_ret  in  signed [DATA_WID]  from adder_pipe data_out
- res_valid  out  [REQ_NUM]  one-hot result strobe
- res_status  out  PE_STATE  returned status
- res_data  out  signed [DATA_WID]  returned sum
- all_done  out  1  one-cycle pulse, all requesters complete
- err  out  1  sticky tag/status mismatch flag

## Operation
- FSM states: IDLE, LOCK, DRAIN.
- IDLE: grant goes to the first i with req_valid[i] & !done[i], searching from rr_ptr upward with wrap. req_ready is combinational from state, rr_ptr and done.
  - An accepted VALID beat moves the FSM to LOCK with owner = i.
  - An accepted CNN_FIN moves rr_ptr to i+1 and the FSM stays in IDLE (single-beat window).
  - An accepted COMPL also sets done[i].
- LOCK: only the owner gets req_ready.
  - VALID beats keep the lock.
  - CNN_FIN releases the lock: rr_ptr = owner+1, FSM goes to IDLE.
  - COMPL releases the lock, sets done[owner] and goes to IDLE.
- Completion: when all done[] bits are set, including the beat just accepted, the FSM goes to DRAIN. No grants are issued in DRAIN. After 1+PIPE_LAT cycles it pulses all_done, clears done[] and rr_ptr, and returns to IDLE.
- Beats whose req_status is INVALID are dropped. They cause no forward and no state change.
- Forward register: on an accepted beat, add_status and add_data take req_status/req_data, and tag = {1, id}. Otherwise add_status = INVALID, add_data holds its value, and tag valid = 0.
- The tag shift register is PIPE_LAT deep and aligns the tag with add_status_ret.
- Return register: if the aligned tag is valid and add_status_ret != INVALID, then res_valid[tag.id] = 1 and res_status/res_data are captured. Otherwise res_valid = 0.
- A tag valid bit that disagrees with (add_status_ret != INVALID) sets err. The result is suppressed.
- There is no backpressure on the return path. Requesters must always accept results.
- Sums wrap modulo 2^DATA_WID, as computed by the adder. This block performs no arithmetic.

## Timing
- Reset values (async, reset low): state = IDLE, rr_ptr = 0, done = 0, tags cleared, add_status = INVALID, add_data = 0, res_valid = 0, res_status = INVALID, res_data = 0, all_done = 0, err = 0, req_ready = 0 while reset is asserted.
- Latency: a beat accepted at edge N appears on add_status after edge N. Its result has res_valid high after edge N+1+PIPE_LAT, which is 3 cycles at default.
- Throughput is one beat per cycle. Back-to-back windows from different requesters have no bubble: the cycle after CNN_FIN, the IDLE arbitration grants immediately.
- Owner drops req_valid in LOCK: the lock is held and INVALID is forwarded. The grant is never taken away mid-window.
- A requester whose done bit is set is never granted until all_done.
- Reset mid-window: everything in flight is discarded and no res_valid follows. The adder must share the same reset.

## Test plan
- Single requester: req0 sends VALID {1,2,3,4}, then CNN_FIN {-86,-86,8,5}. Required: res_valid[0] 3 cycles after each beat with res_data 10 then -159 (wraps to 97), statuses VALID then CNN_FIN.
- Contention: req0 and req1 both hold valid in IDLE with rr_ptr = 0. Required: req0 locked for the VALID, VALID, CNN_FIN window, req1 stalled (ready = 0). req1 granted the cycle after req0's CNN_FIN. Results are tagged to the correct res_valid bit.
- Fairness: both requesters send continuous single-beat CNN_FIN windows. Required: grants alternate 0, 1, 0, 1.
- Completion: req0 sends COMPL, then req1 sends COMPL. Required: no grant to req0 after its COMPL. DRAIN entered after req1's COMPL. all_done pulses exactly once, 3 cycles later. Grants resume afterwards.
- Reset mid-LOCK: reset is pulsed low for 1 cycle with 2 beats in flight. Required: all outputs return to their reset values at once. No res_valid occurs for the flushed beats. err stays 0.
- Mismatch: force add_status_ret = VALID with no tag valid. Required: err goes to 1 and stays there, and res_valid stays 0.

Source files
------------

// File: rtl/adder_pipe_sched.sv
// adder_pipe_sched: shares one adder_pipe between REQ_NUM PE-row requesters.
// Round-robin arbitration, grant locked for a whole accumulation window
// (VALID beats closed by CNN_FIN or COMPL), beats tagged with the requester
// id so results returned by the adder are routed back to their owner.
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   req_valid/status/data per-requester beat (status 2b each, ADD_NUM operands each)
//   req_ready             one-hot grant (combinational)
//   add_status/add_data   registered drive to adder_pipe status_in/data_in
//   add_status_ret/_data_ret  adder_pipe status_out/data_out
//   res_valid/status/data registered result, one-hot strobe per requester
//   all_done              one-cycle pulse after all requesters completed and pipe drained
//   err                   sticky tag/return-status mismatch
// PE_STATE encoding: 0 INVALID, 1 VALID, 2 CNN_FIN, 3 COMPL.
module adder_pipe_sched #(
  parameter int unsigned DATA_WID = 8,
  parameter int unsigned ADD_NUM  = 4,
  parameter int unsigned REQ_NUM  = 2,
  parameter int unsigned PIPE_LAT = 2
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [REQ_NUM-1:0]                    req_valid,
  input  logic [2*REQ_NUM-1:0]                  req_status,
  input  logic [REQ_NUM*ADD_NUM*DATA_WID-1:0]   req_data,
  output logic [REQ_NUM-1:0]                    req_ready,
  output logic [1:0]                            add_status,
  output logic [ADD_NUM*DATA_WID-1:0]           add_data,
  input  logic [1:0]                            add_status_ret,
  input  logic [DATA_WID-1:0]                   add_data_ret,
  output logic [REQ_NUM-1:0]                    res_valid,
  output logic [1:0]                            res_status,
  output logic [DATA_WID-1:0]                   res_data,
  output logic                                  all_done,
  output logic                                  err
);

  localparam int unsigned ID_WID   = $clog2(REQ_NUM);
  localparam int unsigned BEAT_WID = ADD_NUM * DATA_WID;
  localparam int unsigned CNT_WID  = $clog2(PIPE_LAT + 1);

  localparam logic [1:0] PE_INVALID = 2'd0;
  localparam logic [1:0] PE_VALID   = 2'd1;
  localparam logic [1:0] PE_CNN_FIN = 2'd2;
  localparam logic [1:0] PE_COMPL   = 2'd3;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOCK  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]          state, state_nxt;
  logic [ID_WID-1:0]   owner, owner_nxt;
  logic [ID_WID-1:0]   rr_ptr, rr_nxt;
  logic [REQ_NUM-1:0]  done, done_nxt;
  logic [CNT_WID-1:0]  cnt, cnt_nxt;
  logic                pulse_c;

  logic                gnt_found;
  logic [ID_WID-1:0]   gnt_id;
  logic [ID_WID-1:0]   sel_id;
  logic [1:0]          sel_status;
  logic [BEAT_WID-1:0] sel_data;
  logic                beat;

  logic                            tag_fwd_v;
  logic [ID_WID-1:0]               tag_fwd_id;
  logic [PIPE_LAT-1:0]             tag_v_sr;
  logic [PIPE_LAT-1:0][ID_WID-1:0] tag_id_sr;
  logic                            al_v;
  logic [ID_WID-1:0]               al_id;
  logic                            ret_v;

  // Modulo-REQ_NUM increment used for the round-robin search and pointer update.
  function automatic logic [ID_WID-1:0] wrap_inc(input logic [ID_WID-1:0] base,
                                                 input int unsigned off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= REQ_NUM) s = s - REQ_NUM;
    return ID_WID'(s);
  endfunction

  // Round-robin search from rr_ptr over requesters that are valid and not done.
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    for (int unsigned k = 0; k < REQ_NUM; k++) begin
      if (!gnt_found && req_valid[wrap_inc(rr_ptr, k)] && !done[wrap_inc(rr_ptr, k)]) begin
        gnt_found = 1'b1;
        gnt_id    = wrap_inc(rr_ptr, k);
      end
    end
  end

  // Grant: held low during reset, none in DRAIN.
  always_comb begin
    req_ready = '0;
    if (reset) begin
      case (state)
        S_IDLE:  if (gnt_found) req_ready[gnt_id] = 1'b1;
        S_LOCK:  req_ready[owner] = 1'b1;
        default: ;
      endcase
    end
  end

  // Mux the granted requester's beat.
  assign sel_id = (state == S_LOCK) ? owner : gnt_id;

  always_comb begin
    sel_status = PE_INVALID;
    sel_data   = '0;
    for (int unsigned i = 0; i < REQ_NUM; i++) begin
      if (ID_WID'(i) == sel_id) begin
        sel_status = req_status[i*2 +: 2];
        sel_data   = req_data[i*BEAT_WID +: BEAT_WID];
      end
    end
  end

  // INVALID-status beats are handshaken but otherwise ignored.
  assign beat = (|(req_valid & req_ready)) && (sel_status != PE_INVALID);

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    rr_nxt    = rr_ptr;
    done_nxt  = done;
    cnt_nxt   = cnt;
    pulse_c   = 1'b0;
    case (state)
      S_IDLE: begin
        if (beat) begin
          if (sel_status == PE_VALID) begin
            state_nxt = S_LOCK;
            owner_nxt = sel_id;
          end else begin
            rr_nxt = wrap_inc(sel_id, 1);
            if (sel_status == PE_COMPL) done_nxt[sel_id] = 1'b1;
          end
        end
      end
      S_LOCK: begin
        if (beat && (sel_status != PE_VALID)) begin
          state_nxt = S_IDLE;
          rr_nxt    = wrap_inc(owner, 1);
          if (sel_status == PE_COMPL) done_nxt[owner] = 1'b1;
        end
      end
      S_DRAIN: begin
        if (cnt == CNT_WID'(PIPE_LAT)) begin
          pulse_c   = 1'b1;
          state_nxt = S_IDLE;
          done_nxt  = '0;
          rr_nxt    = '0;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_WID'(1);
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    // Last COMPL (including this cycle's beat) starts the drain window.
    if ((state != S_DRAIN) && (&done_nxt)) begin
      state_nxt = S_DRAIN;
      cnt_nxt   = '0;
    end
  end

  // FSM state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      owner    <= '0;
      rr_ptr   <= '0;
      done     <= '0;
      cnt      <= '0;
      all_done <= 1'b0;
    end else begin
      state    <= state_nxt;
      owner    <= owner_nxt;
      rr_ptr   <= rr_nxt;
      done     <= done_nxt;
      cnt      <= cnt_nxt;
      all_done <= pulse_c;
    end
  end

  // Tag aligned with add_status_ret: forward stage plus PIPE_LAT shift stages.
  assign al_v  = tag_v_sr[PIPE_LAT-1];
  assign al_id = tag_id_sr[PIPE_LAT-1];
  assign ret_v = (add_status_ret != PE_INVALID);

  // Forward, tag pipeline and return registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      add_status <= PE_INVALID;
      add_data   <= '0;
      tag_fwd_v  <= 1'b0;
      tag_fwd_id <= '0;
      tag_v_sr   <= '0;
      tag_id_sr  <= '0;
      res_valid  <= '0;
      res_status <= PE_INVALID;
      res_data   <= '0;
      err        <= 1'b0;
    end else begin
      if (beat) begin
        add_status <= sel_status;
        add_data   <= sel_data;
        tag_fwd_v  <= 1'b1;
        tag_fwd_id <= sel_id;
      end else begin
        add_status <= PE_INVALID;
        tag_fwd_v  <= 1'b0;
      end
      for (int unsigned k = PIPE_LAT - 1; k > 0; k--) begin
        tag_v_sr[k]  <= tag_v_sr[k-1];
        tag_id_sr[k] <= tag_id_sr[k-1];
      end
      tag_v_sr[0]  <= tag_fwd_v;
      tag_id_sr[0] <= tag_fwd_id;

      res_valid <= '0;
      if (al_v && ret_v) begin
        res_valid[al_id] <= 1'b1;
        res_status       <= add_status_ret;
        res_data         <= add_data_ret;
      end
      if (al_v != ret_v) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_adder_pipe_sched.sv
module tb_adder_pipe_sched;

  localparam int unsigned DATA_WID = 8;
  localparam int unsigned ADD_NUM  = 4;
  localparam int unsigned REQ_NUM  = 2;
  localparam int unsigned PIPE_LAT = 2;

  localparam logic [1:0] PE_INV  = 2'd0;
  localparam logic [1:0] PE_VAL  = 2'd1;
  localparam logic [1:0] PE_FIN  = 2'd2;
  localparam logic [1:0] PE_CMP  = 2'd3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  req_valid = '0;
  logic [3:0]  req_status = '0;
  logic [63:0] req_data = '0;
  logic [1:0]  req_ready;
  logic [1:0]  add_status;
  logic [31:0] add_data;
  logic [1:0]  add_status_ret;
  logic [7:0]  add_data_ret;
  logic [1:0]  res_valid;
  logic [1:0]  res_status;
  logic [7:0]  res_data;
  logic        all_done;
  logic        err;
  logic        force_ret = 1'b0;

  int checks = 0;
  int errors = 0;

  adder_pipe_sched #(
    .DATA_WID(DATA_WID), .ADD_NUM(ADD_NUM), .REQ_NUM(REQ_NUM), .PIPE_LAT(PIPE_LAT)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_status(req_status), .req_data(req_data),
    .req_ready(req_ready),
    .add_status(add_status), .add_data(add_data),
    .add_status_ret(add_status_ret), .add_data_ret(add_data_ret),
    .res_valid(res_valid), .res_status(res_status), .res_data(res_data),
    .all_done(all_done), .err(err)
  );

  always #5 clk = ~clk;

  // Adder model: sum of four 8-bit operands, PIPE_LAT cycles, shared reset.
  logic [1:0] st_pipe  [PIPE_LAT];
  logic [7:0] sum_pipe [PIPE_LAT];

  function automatic logic [7:0] sum4(input logic [31:0] d);
    return d[7:0] + d[15:8] + d[23:16] + d[31:24];
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < PIPE_LAT; k++) begin
        st_pipe[k]  <= PE_INV;
        sum_pipe[k] <= '0;
      end
    end else begin
      st_pipe[0]  <= add_status;
      sum_pipe[0] <= sum4(add_data);
      for (int k = 1; k < PIPE_LAT; k++) begin
        st_pipe[k]  <= st_pipe[k-1];
        sum_pipe[k] <= sum_pipe[k-1];
      end
    end
  end

  assign add_status_ret = force_ret ? PE_VAL : st_pipe[PIPE_LAT-1];
  assign add_data_ret   = sum_pipe[PIPE_LAT-1];

  function automatic logic [31:0] pack4(input int a, input int b, input int c, input int d);
    return {8'(d), 8'(c), 8'(b), 8'(a)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    req_valid = '0; req_status = '0; req_data = '0; force_ret = 1'b0;
    tick(); tick();
    reset = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    req_valid = 2'b11; req_status = {PE_VAL, PE_VAL};
    tick(); tick();
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b exp 00", req_ready); end
    checks++; if (add_status !== PE_INV) begin errors++; $display("FAIL reset_add_status: got %0d exp 0", add_status); end
    checks++; if (add_data !== 32'd0) begin errors++; $display("FAIL reset_add_data: got %h exp 0", add_data); end
    checks++; if (res_valid !== 2'b00 || res_status !== PE_INV || res_data !== 8'd0) begin
      errors++; $display("FAIL reset_res: got v=%b s=%0d d=%0d exp 00/0/0", res_valid, res_status, res_data); end
    checks++; if (all_done !== 1'b0 || err !== 1'b0) begin
      errors++; $display("FAIL reset_flags: got done=%b err=%b exp 0/0", all_done, err); end
    req_valid = '0; req_status = '0;
  endtask

  task automatic test_single();
    do_reset();
    req_valid = 2'b01; req_status = {PE_INV, PE_VAL}; req_data = {32'd0, pack4(1, 2, 3, 4)}; #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL single_ready0: got %b exp 01", req_ready); end
    tick();
    checks++; if (add_status !== PE_VAL || add_data !== pack4(1, 2, 3, 4)) begin
      errors++; $display("FAIL single_fwd: got s=%0d d=%h exp 1/%h", add_status, add_data, pack4(1, 2, 3, 4)); end
    req_status = {PE_INV, PE_FIN}; req_data = {32'd0, pack4(-86, -86, 8, 5)}; #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL single_ready1: got %b exp 01", req_ready); end
    tick();
    req_valid = 2'b00;
    tick();
    checks++; if (add_status !== PE_INV || add_data !== pack4(-86, -86, 8, 5)) begin
      errors++; $display("FAIL single_fwd_hold: got s=%0d d=%h exp 0/%h", add_status, add_data, pack4(-86, -86, 8, 5)); end
    checks++; if (res_valid !== 2'b00) begin errors++; $display("FAIL single_early: got %b exp 00", res_valid); end
    tick();
    checks++; if (res_valid !== 2'b01 || res_data !== 8'd10 || res_status !== PE_VAL) begin
      errors++; $display("FAIL single_res0: got v=%b d=%0d s=%0d exp 01/10/1", res_valid, res_data, res_status); end
    tick();
    checks++; if (res_valid !== 2'b01 || res_data !== 8'd97 || res_status !== PE_FIN) begin
      errors++; $display("FAIL single_res1: got v=%b d=%0d s=%0d exp 01/97/2", res_valid, res_data, res_status); end
    tick();
    checks++; if (res_valid !== 2'b00) begin errors++; $display("FAIL single_res_end: got %b exp 00", res_valid); end
  endtask

  task automatic test_invalid_drop();
    do_reset();
    req_valid = 2'b01; req_status = {PE_INV, PE_INV}; req_data = {32'd0, pack4(9, 9, 9, 9)};
    tick();
    checks++; if (add_status !== PE_INV || add_data !== 32'd0) begin
      errors++; $display("FAIL drop_fwd: got s=%0d d=%h exp 0/0", add_status, add_data); end
    req_valid = 2'b10; req_status = {PE_VAL, PE_INV}; #1;
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL drop_no_lock: got %b exp 10", req_ready); end
    req_valid = 2'b00;
  endtask

  task automatic test_contention();
    do_reset();
    req_valid = 2'b11; req_status = {PE_FIN, PE_VAL};
    req_data = {pack4(10, 20, 30, 40), pack4(1, 1, 1, 1)}; #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL cont_ready0: got %b exp 01", req_ready); end
    tick();
    req_data[31:0] = pack4(2, 2, 2, 2); #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL cont_ready1: got %b exp 01", req_ready); end
    tick();
    req_status = {PE_FIN, PE_FIN}; req_data[31:0] = pack4(3, 3, 3, 3); #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL cont_ready2: got %b exp 01", req_ready); end
    tick();
    req_valid = 2'b10; #1;
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL cont_ready3: got %b exp 10", req_ready); end
    tick();
    req_valid = 2'b00;
    checks++; if (res_valid !== 2'b01 || res_data !== 8'd4 || res_status !== PE_VAL) begin
      errors++; $display("FAIL cont_res0: got v=%b d=%0d s=%0d exp 01/4/1", res_valid, res_data, res_status); end
    tick();
    checks++; if (res_valid !== 2'b01 || res_data !== 8'd8) begin
      errors++; $display("FAIL cont_res1: got v=%b d=%0d exp 01/8", res_valid, res_data); end
    tick();
    checks++; if (res_valid !== 2'b01 || res_data !== 8'd12 || res_status !== PE_FIN) begin
      errors++; $display("FAIL cont_res2: got v=%b d=%0d s=%0d exp 01/12/2", res_valid, res_data, res_status); end
    tick();
    checks++; if (res_valid !== 2'b10 || res_data !== 8'd100 || res_status !== PE_FIN) begin
      errors++; $display("FAIL cont_res3: got v=%b d=%0d s=%0d exp 10/100/2", res_valid, res_data, res_status); end
  endtask

  task automatic test_fairness();
    logic [1:0] exp_g;
    do_reset();
    req_valid = 2'b11; req_status = {PE_FIN, PE_FIN};
    req_data = {pack4(2, 0, 0, 0), pack4(1, 0, 0, 0)};
    for (int k = 0; k < 4; k++) begin
      exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
      #1;
      checks++; if (req_ready !== exp_g) begin errors++; $display("FAIL fair_grant%0d: got %b exp %b", k, req_ready, exp_g); end
      tick();
    end
    req_valid = 2'b00;
    for (int k = 0; k < 4; k++) begin
      exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
      checks++; if (res_valid !== exp_g || res_data !== 8'((k % 2) + 1)) begin
        errors++; $display("FAIL fair_res%0d: got v=%b d=%0d exp %b/%0d", k, res_valid, res_data, exp_g, (k % 2) + 1); end
      tick();
    end
  endtask

  task automatic test_completion();
    do_reset();
    req_valid = 2'b01; req_status = {PE_INV, PE_CMP}; #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL comp_ready0: got %b exp 01", req_ready); end
    tick();
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL comp_done_block: got %b exp 00", req_ready); end
    req_valid = 2'b11; req_status = {PE_CMP, PE_CMP}; #1;
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL comp_ready1: got %b exp 10", req_ready); end
    tick();
    req_status = {PE_VAL, PE_VAL}; #1;
    checks++; if (req_ready !== 2'b00 || all_done !== 1'b0) begin
      errors++; $display("FAIL comp_drain0: got rdy=%b done=%b exp 00/0", req_ready, all_done); end
    tick();
    checks++; if (req_ready !== 2'b00 || all_done !== 1'b0) begin
      errors++; $display("FAIL comp_drain1: got rdy=%b done=%b exp 00/0", req_ready, all_done); end
    tick();
    checks++; if (req_ready !== 2'b00 || all_done !== 1'b0 || res_valid !== 2'b01 || res_status !== PE_CMP) begin
      errors++; $display("FAIL comp_drain2: got rdy=%b done=%b v=%b s=%0d exp 00/0/01/3", req_ready, all_done, res_valid, res_status); end
    tick();
    checks++; if (all_done !== 1'b1 || res_valid !== 2'b10 || res_status !== PE_CMP) begin
      errors++; $display("FAIL comp_pulse: got done=%b v=%b s=%0d exp 1/10/3", all_done, res_valid, res_status); end
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL comp_resume: got %b exp 01", req_ready); end
    req_valid = 2'b00;
    tick();
    checks++; if (all_done !== 1'b0) begin errors++; $display("FAIL comp_once: got %b exp 0", all_done); end
  endtask

  task automatic test_reset_mid_lock();
    do_reset();
    req_valid = 2'b01; req_status = {PE_INV, PE_VAL}; req_data = {32'd0, pack4(5, 5, 5, 5)};
    tick(); tick();
    reset = 1'b0; #1;
    checks++; if (add_status !== PE_INV || add_data !== 32'd0 || req_ready !== 2'b00) begin
      errors++; $display("FAIL rst_mid_fwd: got s=%0d d=%h rdy=%b exp 0/0/00", add_status, add_data, req_ready); end
    checks++; if (res_valid !== 2'b00 || res_status !== PE_INV || res_data !== 8'd0 || all_done !== 1'b0 || err !== 1'b0) begin
      errors++; $display("FAIL rst_mid_res: got v=%b s=%0d d=%0d done=%b err=%b exp 00/0/0/0/0",
                         res_valid, res_status, res_data, all_done, err); end
    @(posedge clk); #1;
    req_valid = 2'b00;
    reset = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++; if (res_valid !== 2'b00) begin errors++; $display("FAIL rst_mid_flush%0d: got %b exp 00", k, res_valid); end
    end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_mid_err: got %b exp 0", err); end
  endtask

  task automatic test_mismatch();
    do_reset();
    force_ret = 1'b1;
    tick();
    checks++; if (err !== 1'b1 || res_valid !== 2'b00) begin
      errors++; $display("FAIL mis_set: got err=%b v=%b exp 1/00", err, res_valid); end
    force_ret = 1'b0;
    tick(); tick();
    checks++; if (err !== 1'b1 || res_valid !== 2'b00) begin
      errors++; $display("FAIL mis_sticky: got err=%b v=%b exp 1/00", err, res_valid); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_invalid_drop();
    test_contention();
    test_fairness();
    test_completion();
    test_reset_mid_lock();
    test_mismatch();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded 100000 time units");
    $fatal(1);
  end

endmodule
